mpu_store: RTL and testbench

MPU_STORE -- requirements
Module: mpu_store

---
 rtl/mpu_pkg.sv | 21 ++
 rtl/mpu_store_fifo.sv | 63 ++++++
 rtl/mpu_store.sv | 214 +++++++++++++++++++++
 tb/tb_mpu_store.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix processing unit.
// Holds the default geometry of the matrix register file and the
// store-engine state encoding used by mpu_store.
package mpu_pkg;

    // Element width in bits (single-precision float by default).
    localparam int FP              = 32;
    // Largest matrix the register file holds: M rows by N columns.
    localparam int M               = 2;
    localparam int N               = 2;
    // Width of a matrix-register address.
    localparam int MATRIX_REG_SIZE = 4;
    // Depth of the store output buffer.
    localparam int STORE_FIFO_DEPTH = 2;

    typedef enum logic {
        STORE_IDLE   = 1'b0,
        STORE_MATRIX = 1'b1
    } store_state_t;

endpackage : mpu_pkg

// File: rtl/mpu_store_fifo.sv
// Two-entry output buffer for the store engine.
// Each entry carries one matrix element together with its row/col tags
// and the final-element flag. Push is ignored when full, pop when empty.
module mpu_store_fifo #(
    parameter int DW = 32,
    parameter int RW = 1,
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic [RW-1:0] i_push_row,
    input  logic [CW-1:0] i_push_col,
    input  logic          i_push_last,
    input  logic          i_pop,
    output logic [1:0]    o_count,
    output logic [DW-1:0] o_head_data,
    output logic [RW-1:0] o_head_row,
    output logic [CW-1:0] o_head_col,
    output logic          o_head_last
);

    localparam int EW = DW + RW + CW + 1;

    logic [EW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok = i_push && (r_count != 2'd2);
    assign w_pop_ok  = i_pop  && (r_count != 2'd0);

    // Storage, pointers and occupancy; head is whatever the read pointer selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two entries are reset so the head outputs read 0 while in reset; a deep RAM would not be.
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= {i_push_data, i_push_row, i_push_col, i_push_last};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push_ok) - 2'(w_pop_ok);
        end
    end

    assign o_count = r_count;
    assign {o_head_data, o_head_row, o_head_col, o_head_last} = r_mem[r_rd_ptr];

endmodule : mpu_store_fifo

// File: rtl/mpu_store.sv
// Matrix store engine: reads an m x n matrix out of the register file in
// row-major order and streams the elements, tagged with row/col/last, over a
// valid/ready interface. At most one register read is outstanding and the
// 2-entry output buffer is never overcommitted.
// Optional build macro MPU_STORE_ERR_CHECK_EN: reject requests whose
// dimensions are zero or exceed M/N, pulsing store_error instead of starting.
module mpu_store #(
    parameter int FP              = mpu_pkg::FP,
    parameter int M               = mpu_pkg::M,
    parameter int N               = mpu_pkg::N,
    parameter int MATRIX_REG_SIZE = mpu_pkg::MATRIX_REG_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_req,
    input  logic [MATRIX_REG_SIZE-1:0] store_addr,
    input  logic [$clog2(M):0]         store_m,
    input  logic [$clog2(N):0]         store_n,
    output logic                       store_ready,
    output logic                       reg_rd_en,
    output logic [MATRIX_REG_SIZE-1:0] reg_rd_addr,
    output logic [$clog2(M*N)-1:0]     reg_rd_idx,
    input  logic [FP-1:0]              reg_rd_data,
    output logic [FP-1:0]              element_out,
    output logic                       element_valid,
    input  logic                       element_ready,
    output logic [$clog2(M)-1:0]       row_out,
    output logic [$clog2(N)-1:0]       col_out,
    output logic                       last_out,
    output logic                       store_done,
    output logic                       store_error
);

    import mpu_pkg::store_state_t;
    import mpu_pkg::STORE_IDLE;
    import mpu_pkg::STORE_MATRIX;

    localparam int IDXW = $clog2(M*N);
    localparam int RW   = $clog2(M);
    localparam int CW   = $clog2(N);
    localparam int MW   = $clog2(M) + 1;
    localparam int NW   = $clog2(N) + 1;

    store_state_t r_state;
    store_state_t w_next_state;

    // Latched request
    logic [MATRIX_REG_SIZE-1:0] r_addr;
    logic [MW-1:0]              r_m;
    logic [NW-1:0]              r_n;

    // Read-issue cursor
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_issue_done;

    // Tags of the read whose data arrives this cycle
    logic          r_inflight;
    logic [RW-1:0] r_inf_row;
    logic [CW-1:0] r_inf_col;
    logic          r_inf_last;

    logic r_done;

    logic       w_accept;
    logic       w_pop;
    logic       w_row_last;
    logic       w_col_last;
    logic       w_head_last;
    logic [1:0] w_fifo_count;
    logic [2:0] w_occupancy;

    assign w_row_last = (MW'(r_row) == (r_m - MW'(1)));
    assign w_col_last = (NW'(r_col) == (r_n - NW'(1)));

    // Buffered elements plus the read in flight, minus the one leaving now.
    assign w_pop       = element_valid && element_ready;
    assign w_occupancy = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);

`ifdef MPU_STORE_ERR_CHECK_EN
    logic r_err;
    logic w_dims_bad;

    assign w_dims_bad = (store_m == '0) || (store_n == '0) ||
                        (store_m > MW'(M)) || (store_n > NW'(N));
    assign w_accept   = store_req && store_ready && !w_dims_bad;

    // Rejection pulse one cycle after a bad request is presented while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= store_req && store_ready && w_dims_bad;
        end
    end

    assign store_error = r_err;
`else
    assign w_accept    = store_req && store_ready;
    assign store_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STORE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: start on accept, finish when the last-tagged element leaves.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            STORE_IDLE:   if (w_accept)              w_next_state = STORE_MATRIX;
            STORE_MATRIX: if (w_pop && w_head_last)  w_next_state = STORE_IDLE;
            default:                                 w_next_state = STORE_IDLE;
        endcase
    end

    // Outputs decoded from state: idle flag and read strobe with buffer credit.
    always_comb begin
        store_ready = 1'b0;
        reg_rd_en   = 1'b0;
        case (r_state)
            STORE_IDLE:   store_ready = 1'b1;
            STORE_MATRIX: reg_rd_en   = !r_issue_done && (w_occupancy < 3'd2);
            default:      ;
        endcase
    end

    // Request latch, row-major read cursor and in-flight tag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_m          <= '0;
            r_n          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_issue_done <= 1'b0;
            r_inflight   <= 1'b0;
            r_inf_row    <= '0;
            r_inf_col    <= '0;
            r_inf_last   <= 1'b0;
        end else begin
            r_inflight <= reg_rd_en;
            if (reg_rd_en) begin
                r_inf_row  <= r_row;
                r_inf_col  <= r_col;
                r_inf_last <= w_row_last && w_col_last;
            end

            if (w_accept) begin
                r_addr       <= store_addr;
                r_m          <= store_m;
                r_n          <= store_n;
                r_row        <= '0;
                r_col        <= '0;
                r_issue_done <= 1'b0;
            end else if (reg_rd_en) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Completion pulse in the cycle after the final element is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == STORE_MATRIX) && w_pop && w_head_last;
        end
    end

    assign store_done  = r_done;
    assign reg_rd_addr = r_addr;
    assign reg_rd_idx  = IDXW'(r_row) * IDXW'(N) + IDXW'(r_col);

    // Read data lands in the buffer on the edge after it is valid.
    mpu_store_fifo #(
        .DW (FP),
        .RW (RW),
        .CW (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (reg_rd_data),
        .i_push_row  (r_inf_row),
        .i_push_col  (r_inf_col),
        .i_push_last (r_inf_last),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_head_data (element_out),
        .o_head_row  (row_out),
        .o_head_col  (col_out),
        .o_head_last (w_head_last)
    );

    assign element_valid = (w_fifo_count != 2'd0);
    assign last_out      = w_head_last;

endmodule : mpu_store

// File: tb/tb_mpu_store.sv
// Self-checking bench for mpu_store. A behavioural register file answers
// reads one cycle later; directed request vectors carry their hand-derived
// first-valid and done cycles, and element data/tags come from the register
// contents and row-major order. Build with +define+MPU_STORE_ERR_CHECK_EN
// to include the dimension-rejection sequence.
module tb_mpu_store;

    localparam int TB_N = 2;

    logic        clk;
    logic        rst;
    logic        store_req;
    logic [3:0]  store_addr;
    logic [1:0]  store_m;
    logic [1:0]  store_n;
    logic        store_ready;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_addr;
    logic [1:0]  reg_rd_idx;
    logic [31:0] reg_rd_data;
    logic [31:0] element_out;
    logic        element_valid;
    logic        element_ready;
    logic        row_out;
    logic        col_out;
    logic        last_out;
    logic        store_done;
    logic        store_error;

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_count  = 0;
    int rd7_count = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [1:0]  m;
        logic [1:0]  n;
        logic [15:0] rdy;        // element_ready per cycle after accept, bit0 = cycle 1
        int          exp_first;  // cycle of first element_valid
        int          exp_done;   // cycle of store_done
        bit          busy;       // hammer store_req to reg 7 while busy
    } vec_t;

    vec_t vecs[6];

    mpu_store dut (
        .clk           (clk),
        .rst           (rst),
        .store_req     (store_req),
        .store_addr    (store_addr),
        .store_m       (store_m),
        .store_n       (store_n),
        .store_ready   (store_ready),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_idx    (reg_rd_idx),
        .reg_rd_data   (reg_rd_data),
        .element_out   (element_out),
        .element_valid (element_valid),
        .element_ready (element_ready),
        .row_out       (row_out),
        .col_out       (col_out),
        .last_out      (last_out),
        .store_done    (store_done),
        .store_error   (store_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register contents: reg 5 holds 1.0..4.0, every other register a tagged pattern.
    function automatic logic [31:0] ref_data(input logic [3:0] a, input int idx);
        logic [31:0] v;
        if (a == 4'd5) begin
            case (idx)
                0:       v = 32'h3F80_0000;
                1:       v = 32'h4000_0000;
                2:       v = 32'h4040_0000;
                default: v = 32'h4080_0000;
            endcase
        end else begin
            v = 32'hC0DE_0000 | (32'(a) << 8) | 32'(idx);
        end
        return v;
    endfunction

    // Register file: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        reg_rd_data <= reg_rd_en ? ref_data(reg_rd_addr, int'(reg_rd_idx)) : 32'hDEAD_BEEF;
    end

    // Read monitor.
    always @(posedge clk) begin
        if (reg_rd_en) begin
            rd_count <= rd_count + 1;
            if (reg_rd_addr == 4'd7) rd7_count <= rd7_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request at a negedge and follow it to store_done.
    task automatic run_store(input vec_t v);
        int  e, first, last_pop, rd0, r70, total, nn, row, col;
        bit  got_done;
        total    = int'(v.m) * int'(v.n);
        nn       = int'(v.n);
        e        = 0;
        first    = -1;
        last_pop = -100;
        got_done = 1'b0;
        rd0      = rd_count;
        r70      = rd7_count;
        check("idle_ready", store_ready, 1'b1);
        store_req     = 1'b1;
        store_addr    = v.addr;
        store_m       = v.m;
        store_n       = v.n;
        element_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            element_ready = (cyc <= 16) ? v.rdy[cyc-1] : 1'b1;
            if (v.busy && cyc <= 4) begin
                store_req  = 1'b1;
                store_addr = 4'd7;
            end else begin
                store_req  = 1'b0;
            end
            check("store_error_low", store_error, 1'b0);
            if (store_done) begin
                got_done = 1'b1;
                check("done_cycle", cyc, v.exp_done);
                check("done_after_pop", cyc, last_pop + 1);
                check("handshakes", e, total);
                check("ready_at_done", store_ready, 1'b1);
                check("valid_at_done", element_valid, 1'b0);
            end else begin
                check("busy_not_ready", store_ready, 1'b0);
                check("outstanding_le2", ((rd_count - rd0) - e) <= 2, 1'b1);
                if (element_valid) begin
                    if (first < 0) begin
                        first = cyc;
                        check("first_valid", cyc, v.exp_first);
                    end
                    check("elem_in_range", e < total, 1'b1);
                    if (e < total) begin
                        row = e / nn;
                        col = e % nn;
                        check("data", element_out, ref_data(v.addr, row * TB_N + col));
                        check("row", row_out, row);
                        check("col", col_out, col);
                        check("last", last_out, e == total - 1);
                    end
                    if (element_ready) begin
                        e++;
                        last_pop = cyc;
                    end
                end
            end
            if (!got_done) @(negedge clk);
        end
        store_req = 1'b0;
        check("done_seen", got_done, 1'b1);
        check("reads_issued", rd_count - rd0, total);
        check("no_reads_reg7", rd7_count - r70, 0);
        @(negedge clk);
        check("done_one_cycle", store_done, 1'b0);
        check("idle_after", store_ready, 1'b1);
        check("valid_after", element_valid, 1'b0);
    endtask

    initial begin
        int pops;
        int rd0;

        //               addr   m     n     rdy       first done busy
        vecs[0] = '{4'd5, 2'd2, 2'd2, 16'hFFFF, 3, 7, 1'b0};  // 1.0..4.0 streaming
        vecs[1] = '{4'd2, 2'd2, 2'd1, 16'hFFE7, 3, 7, 1'b0};  // stalls on (1,0)
        vecs[2] = '{4'd6, 2'd2, 2'd2, 16'hFFFF, 3, 7, 1'b1};  // request while busy
        vecs[3] = '{4'd3, 2'd1, 2'd1, 16'hFFFF, 3, 4, 1'b0};  // single element
        vecs[4] = '{4'd9, 2'd2, 2'd2, 16'hFFF3, 3, 9, 1'b0};  // full buffer backpressure
        vecs[5] = '{4'd1, 2'd1, 2'd2, 16'hFFFF, 3, 5, 1'b0};  // one row

        rst           = 1'b1;
        store_req     = 1'b0;
        store_addr    = 4'd0;
        store_m       = 2'd0;
        store_n       = 2'd0;
        element_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_store_ready", store_ready, 1'b1);
        check("rst_valid", element_valid, 1'b0);
        check("rst_rd_en", reg_rd_en, 1'b0);
        check("rst_rd_addr", reg_rd_addr, 4'd0);
        check("rst_rd_idx", reg_rd_idx, 2'd0);
        check("rst_element", element_out, 32'd0);
        check("rst_row", row_out, 1'b0);
        check("rst_col", col_out, 1'b0);
        check("rst_last", last_out, 1'b0);
        check("rst_done", store_done, 1'b0);
        check("rst_error", store_error, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_store(vecs[i]);
        end

        // Reset in the middle of a 2x2 transfer, after two elements.
        check("mid_idle", store_ready, 1'b1);
        store_req     = 1'b1;
        store_addr    = 4'd5;
        store_m       = 2'd2;
        store_n       = 2'd2;
        element_ready = 1'b1;
        @(negedge clk);
        store_req = 1'b0;
        pops = 0;
        for (int cyc = 1; cyc <= 20 && pops < 2; cyc++) begin
            if (element_valid && element_ready) pops++;
            @(negedge clk);
        end
        check("pre_reset_pops", pops, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", element_valid, 1'b0);
        check("mid_rst_ready", store_ready, 1'b1);
        check("mid_rst_rd_en", reg_rd_en, 1'b0);
        check("mid_rst_done", store_done, 1'b0);
        check("mid_rst_last", last_out, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mid_rst_hold_done", store_done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", store_done, 1'b0);
        check("post_rst_valid", element_valid, 1'b0);
        run_store(vecs[0]);

`ifdef MPU_STORE_ERR_CHECK_EN
        // Zero-row request is rejected with a single error pulse and no reads.
        rd0        = rd_count;
        store_req  = 1'b1;
        store_addr = 4'd4;
        store_m    = 2'd0;
        store_n    = 2'd2;
        @(negedge clk);
        store_req = 1'b0;
        check("err_pulse", store_error, 1'b1);
        check("err_stays_idle", store_ready, 1'b1);
        @(negedge clk);
        check("err_one_cycle", store_error, 1'b0);
        repeat (3) @(negedge clk);
        check("err_no_reads", rd_count - rd0, 0);
        check("err_no_valid", element_valid, 1'b0);
        run_store(vecs[3]);
`else
        rd0 = rd_count;
        repeat (3) @(negedge clk);
        check("idle_no_reads", rd_count - rd0, 0);
        check("idle_error_low", store_error, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mpu_store
